wb_retire_monitor: RTL and testbench
====================================

Name: wb_retire_monitor

Overview:
- Sits directly downstream of the write-back pipeline register and consumes the W-stage outputs (W_stat, W_icode, W_stall).
- Also samples pipeline-control and memory-stage signals to keep performance counters.
- Tracks processor run state: running, halted, or faulted, with a sticky final status.
- Exposes counters through a registered debug read port for the testbench and future host logic.

Parameters:
- CNT_W, 32, width of every performance counter; counters saturate at all-ones.
- NOP_ICODE, 4'h1, icode treated as non-retiring (nop or inserted bubble).
- HALT_ICODE, 4'h0, halt icode.
- JXX_ICODE, 4'h7, conditional-jump icode used for mispredict counting.

Ports:
- clk  in  1  system clock; all state updates on rising edge.
- rst  in  1  asynchronous, active-low reset.
- clr  in  1  synchronous clear: zeroes counters and returns to RUN.
- W_stat  in  2  write-back status: 0 AOK, 1 HLT, 2 ADR, 3 INS.
- W_icode  in  4  write-back icode.
- W_stall  in  1  W register stalled this cycle.
- F_stall  in  1  fetch stall from pipeline control.
- E_bubble  in  1  execute bubble from pipeline control.
- M_icode  in  4  memory-stage icode.
- M_Cnd  in  1  memory-stage condition flag.
- rd_sel  in  3  debug counter select.
- rd_data  out  64  registered debug read data, zero-extended.
- cpu_stat  out  2  sticky final status; 0 while running.
- running  out  1  high in RUN.
- halted  out  1  high in HALT.
- faulted  out  1  high in FAULT.

Behaviour:
- Reset (rst=0, asynchronous): state=RUN, all counters=0, cpu_stat=0, rd_data=0, running=1, halted=0, faulted=0.
- Retire event: "ret" = running && !W_stall && W_icode!=NOP_ICODE.
- States:
  - RUN -> HALT when ret && W_stat==1.
  - RUN -> FAULT when ret && W_stat in {2,3}.
  - HALT and FAULT are absorbing; only rst or clr leave them, returning to RUN.
- cpu_stat is latched with W_stat on the transition edge. It is cleared by rst or clr.
- Counters (increment only in RUN, in the same cycle as the condition; saturate at 2^CNT_W-1, no wrap):
  - cyc_cnt: every RUN cycle, including the halting/faulting cycle.
  - ret_cnt: ret && W_stat in {0,1}. The halt instruction counts; a faulting instruction does not.
  - stall_cnt: F_stall.
  - bub_cnt: E_bubble.
  - mis_cnt: M_icode==JXX_ICODE && !M_Cnd (mispredicted taken-prediction jump).
- In HALT/FAULT all counters are frozen. Inputs are ignored except clr.
- clr has priority over every same-cycle event: counters go to 0 and state goes to RUN. A simultaneous halt/fault is discarded.
- Debug read is registered, 1-cycle latency: rd_data on edge N+1 reflects rd_sel and counter values after edge N.
  - rd_sel 0 = cyc_cnt, 1 = ret_cnt, 2 = stall_cnt, 3 = bub_cnt, 4 = mis_cnt.
  - rd_sel 5 = {58'b0, state[1:0], 2'b0, cpu_stat}, with state encoding RUN 0, HALT 1, FAULT 2.
  - rd_sel 6,7 = 0.
- W_stall high: no retire and no state transition, even if W_stat is non-AOK; cyc_cnt still increments.
- Reset asserted mid-run clears everything immediately, without waiting for a clock edge.
- Status values outside 0..3 cannot occur (2-bit field); X on inputs is not handled.

Test Plan:
- Reset then 10 cycles of W_icode=2, W_stat=0, no stall -> cyc_cnt=10, ret_cnt=10, running=1, rd_sel=0 gives 10 one cycle later.
- 5 retires, then W_icode=0, W_stat=1 -> halted=1, cpu_stat=1, ret_cnt=6, cyc_cnt=6; 20 further cycles leave all counters unchanged.
- W_icode=5, W_stat=2 with W_stall=1 for 3 cycles, then W_stall=0 -> no transition during the stall; faulted=1, cpu_stat=2 after the release edge; ret_cnt excludes the faulting instruction.
- cyc_cnt preloaded near saturation (CNT_W=4 build), run 20 cycles -> cyc_cnt holds 15, never wraps to 0.
- M_icode=7, M_Cnd=0 for 3 cycles and M_Cnd=1 for 2 cycles; F_stall pulsed 4 cycles; E_bubble pulsed 2 cycles -> mis_cnt=3, stall_cnt=4, bub_cnt=2.
- clr asserted in the same cycle as a W_stat=1 retire -> state RUN, all counters 0, cpu_stat=0. Then rst pulsed low mid-cycle -> outputs reset before the next clk edge.

Source files
------------

// File: rtl/wb_retire_monitor.sv
// Retirement monitor behind the write-back register: tracks run/halt/fault state,
// keeps saturating performance counters and serves them on a registered debug port.
module wb_retire_monitor #(
    parameter int         CNT_W      = 32,
    parameter logic [3:0] NOP_ICODE  = 4'h1,
    parameter logic [3:0] HALT_ICODE = 4'h0,
    parameter logic [3:0] JXX_ICODE  = 4'h7
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        clr,
    input  logic [1:0]  W_stat,
    input  logic [3:0]  W_icode,
    input  logic        W_stall,
    input  logic        F_stall,
    input  logic        E_bubble,
    input  logic [3:0]  M_icode,
    input  logic        M_Cnd,
    input  logic [2:0]  rd_sel,
    output logic [63:0] rd_data,
    output logic [1:0]  cpu_stat,
    output logic        running,
    output logic        halted,
    output logic        faulted
);

    // A halt instruction has to retire to stop the machine, so it can never share the nop code.
    if (HALT_ICODE == NOP_ICODE) begin : gBadIcodeCfg
        $error("wb_retire_monitor: HALT_ICODE must differ from NOP_ICODE");
    end

    typedef enum logic [1:0] {
        RUN   = 2'd0,
        HALT  = 2'd1,
        FAULT = 2'd2
    } runState_t;

    runState_t        state, stateNext;
    logic [CNT_W-1:0] cycCnt, retCnt, stallCnt, bubCnt, misCnt;
    logic [1:0]       cpuStat;
    logic [63:0]      rdData, rdNext;
    logic             ret;

    function automatic logic [CNT_W-1:0] satInc(input logic [CNT_W-1:0] v, input logic en);
        return (en && (v != '1)) ? v + CNT_W'(1) : v;
    endfunction

    assign running  = (state == RUN);
    assign halted   = (state == HALT);
    assign faulted  = (state == FAULT);
    assign cpu_stat = cpuStat;
    assign rd_data  = rdData;

    // A stalled W register holds its instruction, so nothing retires and no transition fires.
    assign ret = running && !W_stall && (W_icode != NOP_ICODE);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= RUN;
        else      state <= stateNext;
    end

    always_comb begin
        stateNext = state;
        if (clr) begin
            stateNext = RUN;
        end else if (ret) begin
            if (W_stat == 2'd1)  stateNext = HALT;
            else if (W_stat[1])  stateNext = FAULT;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cpuStat <= 2'd0;
        end else if (clr) begin
            cpuStat <= 2'd0;
        end else if (ret && (W_stat != 2'd0)) begin
            cpuStat <= W_stat;
        end
    end

    // Counters move only while running; the cycle that halts or faults is still counted.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cycCnt   <= '0;
            retCnt   <= '0;
            stallCnt <= '0;
            bubCnt   <= '0;
            misCnt   <= '0;
        end else if (clr) begin
            cycCnt   <= '0;
            retCnt   <= '0;
            stallCnt <= '0;
            bubCnt   <= '0;
            misCnt   <= '0;
        end else if (running) begin
            cycCnt   <= satInc(cycCnt, 1'b1);
            retCnt   <= satInc(retCnt, ret && !W_stat[1]);
            stallCnt <= satInc(stallCnt, F_stall);
            bubCnt   <= satInc(bubCnt, E_bubble);
            misCnt   <= satInc(misCnt, (M_icode == JXX_ICODE) && !M_Cnd);
        end
    end

    always_comb begin
        rdNext = 64'd0;
        case (rd_sel)
            3'd0:    rdNext = 64'(cycCnt);
            3'd1:    rdNext = 64'(retCnt);
            3'd2:    rdNext = 64'(stallCnt);
            3'd3:    rdNext = 64'(bubCnt);
            3'd4:    rdNext = 64'(misCnt);
            3'd5:    rdNext = {58'd0, state, 2'd0, cpuStat};
            default: rdNext = 64'd0;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) rdData <= 64'd0;
        else      rdData <= rdNext;
    end

endmodule

// File: tb/tb_wb_retire_monitor.sv
// Bench for wb_retire_monitor: directed table, hand-written corner sequences and
// randomized traffic checked against a behavioural model of the retirement rules.
module tb_wb_retire_monitor;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        clr = 1'b0;
    logic [1:0]  W_stat = 2'd0;
    logic [3:0]  W_icode = 4'd1;
    logic        W_stall = 1'b0;
    logic        F_stall = 1'b0;
    logic        E_bubble = 1'b0;
    logic [3:0]  M_icode = 4'd0;
    logic        M_Cnd = 1'b0;
    logic [2:0]  rd_sel = 3'd0;
    logic [63:0] rd_data;
    logic [1:0]  cpu_stat;
    logic        running, halted, faulted;
    logic [63:0] rdSat;
    logic [1:0]  statSat;
    logic        runSat, haltSat, faultSat;

    int checks = 0;
    int errors = 0;

    wb_retire_monitor dut (
        .clk(clk), .rst(rst), .clr(clr), .W_stat(W_stat), .W_icode(W_icode),
        .W_stall(W_stall), .F_stall(F_stall), .E_bubble(E_bubble), .M_icode(M_icode),
        .M_Cnd(M_Cnd), .rd_sel(rd_sel), .rd_data(rd_data), .cpu_stat(cpu_stat),
        .running(running), .halted(halted), .faulted(faulted)
    );

    wb_retire_monitor #(.CNT_W(4)) dutSat (
        .clk(clk), .rst(rst), .clr(clr), .W_stat(W_stat), .W_icode(W_icode),
        .W_stall(W_stall), .F_stall(F_stall), .E_bubble(E_bubble), .M_icode(M_icode),
        .M_Cnd(M_Cnd), .rd_sel(rd_sel), .rd_data(rdSat), .cpu_stat(statSat),
        .running(runSat), .halted(haltSat), .faulted(faultSat)
    );

    always #5 clk = ~clk;

    // Reference model: plain counters and a run/halt/fault code, advanced once per edge.
    longint     mCyc, mRet, mStall, mBub, mMis;
    int         mState;   // 0 running, 1 halted, 2 faulted
    logic [1:0] mStat;
    logic [63:0] mRd;
    localparam longint CNT_MAX = 64'hFFFF_FFFF;

    function automatic longint bump(input longint v);
        return (v < CNT_MAX) ? v + 1 : v;
    endfunction

    task automatic modelReset();
        mCyc = 0; mRet = 0; mStall = 0; mBub = 0; mMis = 0;
        mState = 0; mStat = 2'd0; mRd = 64'd0;
    endtask

    task automatic modelEdge();
        logic [63:0] view;
        case (rd_sel)
            3'd0: view = mCyc;
            3'd1: view = mRet;
            3'd2: view = mStall;
            3'd3: view = mBub;
            3'd4: view = mMis;
            3'd5: view = 64'(mState * 16 + int'(mStat));
            default: view = 64'd0;
        endcase
        if (clr) begin
            mCyc = 0; mRet = 0; mStall = 0; mBub = 0; mMis = 0;
            mState = 0; mStat = 2'd0;
        end else if (mState == 0) begin
            mCyc = bump(mCyc);
            if (F_stall) mStall = bump(mStall);
            if (E_bubble) mBub = bump(mBub);
            if (M_icode == 4'h7 && !M_Cnd) mMis = bump(mMis);
            if (!W_stall && W_icode != 4'h1) begin
                if (W_stat <= 2'd1) mRet = bump(mRet);
                if (W_stat != 2'd0) begin
                    mState = (W_stat == 2'd1) ? 1 : 2;
                    mStat  = W_stat;
                end
            end
        end
        mRd = view;
    endtask

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic checkModel();
        chk("rd_data", rd_data, mRd);
        chk("cpu_stat", 64'(cpu_stat), 64'(mStat));
        chk("running", 64'(running), 64'(mState == 0));
        chk("halted", 64'(halted), 64'(mState == 1));
        chk("faulted", 64'(faulted), 64'(mState == 2));
    endtask

    task automatic step();
        @(posedge clk);
        modelEdge();
        #1;
        checkModel();
    endtask

    task automatic idleInputs();
        clr = 0; W_stat = 0; W_icode = 4'd1; W_stall = 0; F_stall = 0;
        E_bubble = 0; M_icode = 0; M_Cnd = 0; rd_sel = 0;
    endtask

    task automatic doReset();
        idleInputs();
        #2;
        rst = 0;
        #1;
        modelReset();
        chk("reset_rd", rd_data, 64'd0);
        chk("reset_stat", 64'(cpu_stat), 64'd0);
        chk("reset_flags", {61'd0, running, halted, faulted}, 64'b100);
        @(negedge clk);
        rst = 1;
    endtask

    typedef struct {
        logic [1:0]  stat;
        logic [3:0]  icode;
        logic        wStall, fStall, eBub, clrIn;
        logic [2:0]  sel;
        logic [2:0]  eFlags;  // {running, halted, faulted}
        logic [1:0]  eStat;
        logic [63:0] eRd;
    } vec_t;

    vec_t vecs[13];

    initial begin
        vecs[0]  = '{2'd0, 4'd2, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 3'b100, 2'd0, 64'd0};
        vecs[1]  = '{2'd0, 4'd2, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 3'b100, 2'd0, 64'd1};
        vecs[2]  = '{2'd2, 4'd5, 1'b1, 1'b0, 1'b0, 1'b0, 3'd1, 3'b100, 2'd0, 64'd2};
        vecs[3]  = '{2'd2, 4'd5, 1'b1, 1'b0, 1'b0, 1'b0, 3'd5, 3'b100, 2'd0, 64'd0};
        vecs[4]  = '{2'd2, 4'd5, 1'b1, 1'b1, 1'b0, 1'b0, 3'd0, 3'b100, 2'd0, 64'd4};
        vecs[5]  = '{2'd2, 4'd5, 1'b0, 1'b0, 1'b0, 1'b0, 3'd2, 3'b001, 2'd2, 64'd1};
        vecs[6]  = '{2'd0, 4'd2, 1'b0, 1'b0, 1'b0, 1'b0, 3'd5, 3'b001, 2'd2, 64'h22};
        vecs[7]  = '{2'd0, 4'd2, 1'b0, 1'b1, 1'b0, 1'b0, 3'd0, 3'b001, 2'd2, 64'd6};
        vecs[8]  = '{2'd0, 4'd2, 1'b0, 1'b0, 1'b0, 1'b0, 3'd1, 3'b001, 2'd2, 64'd2};
        vecs[9]  = '{2'd0, 4'd2, 1'b0, 1'b0, 1'b1, 1'b0, 3'd3, 3'b001, 2'd2, 64'd0};
        vecs[10] = '{2'd1, 4'd0, 1'b0, 1'b0, 1'b0, 1'b1, 3'd7, 3'b100, 2'd0, 64'd0};
        vecs[11] = '{2'd0, 4'd2, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 3'b100, 2'd0, 64'd0};
        vecs[12] = '{2'd0, 4'd2, 1'b0, 1'b0, 1'b0, 1'b0, 3'd6, 3'b100, 2'd0, 64'd0};

        // Directed table: stalled fault, frozen counters, clear out of FAULT.
        doReset();
        for (int i = 0; i < 13; i++) begin
            W_stat = vecs[i].stat; W_icode = vecs[i].icode; W_stall = vecs[i].wStall;
            F_stall = vecs[i].fStall; E_bubble = vecs[i].eBub; clr = vecs[i].clrIn;
            rd_sel = vecs[i].sel;
            step();
            chk($sformatf("vec%0d_rd", i), rd_data, vecs[i].eRd);
            chk($sformatf("vec%0d_flags", i), 64'({running, halted, faulted}), 64'(vecs[i].eFlags));
            chk($sformatf("vec%0d_stat", i), 64'(cpu_stat), 64'(vecs[i].eStat));
        end

        // Ten plain retires, then read cycle and retire counts.
        doReset();
        W_icode = 4'd2; W_stat = 2'd0; rd_sel = 3'd0;
        for (int i = 0; i < 10; i++) step();
        W_icode = 4'd1;
        step();
        chk("ten_cyc", rd_data, 64'd10);
        rd_sel = 3'd1;
        step();
        chk("ten_ret", rd_data, 64'd10);
        chk("ten_running", 64'(running), 64'd1);

        // Five retires, halt, then twenty ignored cycles.
        doReset();
        W_icode = 4'd2;
        for (int i = 0; i < 5; i++) step();
        W_icode = 4'd0; W_stat = 2'd1;
        step();
        chk("halt_flag", 64'(halted), 64'd1);
        chk("halt_stat", 64'(cpu_stat), 64'd1);
        for (int i = 0; i < 18; i++) begin
            W_stat = 2'($urandom_range(0, 3)); W_icode = 4'($urandom);
            W_stall = 1'($urandom); F_stall = 1'($urandom); E_bubble = 1'($urandom);
            M_icode = 4'd7; M_Cnd = 1'b0; rd_sel = 3'($urandom_range(0, 5));
            step();
        end
        rd_sel = 3'd0;
        step();
        chk("halt_cyc", rd_data, 64'd6);
        rd_sel = 3'd1;
        step();
        chk("halt_ret", rd_data, 64'd6);
        chk("halt_held", 64'(halted), 64'd1);

        // Saturation on the 4-bit build: the cycle count must stick at 15.
        doReset();
        W_icode = 4'd2; W_stat = 2'd0; rd_sel = 3'd0;
        for (int k = 1; k <= 21; k++) begin
            step();
            if (k >= 2) chk($sformatf("sat_cyc%0d", k), rdSat, (k - 1 > 15) ? 64'd15 : 64'(k - 1));
        end

        // Mispredict, fetch-stall and bubble counting.
        doReset();
        for (int i = 0; i < 5; i++) begin
            M_icode = 4'd7; M_Cnd = (i >= 3); F_stall = (i < 4); E_bubble = (i < 2);
            step();
        end
        M_icode = 4'd0; M_Cnd = 0; F_stall = 0; E_bubble = 0;
        rd_sel = 3'd4; step(); chk("mis_cnt", rd_data, 64'd3);
        rd_sel = 3'd2; step(); chk("stall_cnt", rd_data, 64'd4);
        rd_sel = 3'd3; step(); chk("bub_cnt", rd_data, 64'd2);

        // clr beats a same-cycle halt; then an asynchronous reset mid-cycle.
        doReset();
        W_icode = 4'd2;
        for (int i = 0; i < 3; i++) step();
        clr = 1; W_icode = 4'd0; W_stat = 2'd1;
        step();
        chk("clr_flags", 64'({running, halted, faulted}), 64'b100);
        chk("clr_stat", 64'(cpu_stat), 64'd0);
        clr = 0; W_icode = 4'd1; W_stat = 2'd0; rd_sel = 3'd0;
        step(); chk("clr_cyc", rd_data, 64'd0);
        rd_sel = 3'd1;
        step(); chk("clr_ret", rd_data, 64'd0);
        W_icode = 4'd0; W_stat = 2'd1;
        step();
        W_icode = 4'd1; W_stat = 2'd0; rd_sel = 3'd0;
        step();
        chk("pre_rst_rd", rd_data, 64'd3);
        #2;
        rst = 0;
        #1;
        modelReset();
        chk("async_rst_flags", 64'({running, halted, faulted}), 64'b100);
        chk("async_rst_stat", 64'(cpu_stat), 64'd0);
        chk("async_rst_rd", rd_data, 64'd0);
        @(negedge clk);
        rst = 1;

        // Randomized traffic against the model.
        for (int i = 0; i < 400; i++) begin
            clr = ($urandom_range(0, 39) == 0);
            W_stat = ($urandom_range(0, 15) == 0) ? 2'($urandom_range(1, 3)) : 2'd0;
            W_icode = 4'($urandom); W_stall = ($urandom_range(0, 3) == 0);
            F_stall = 1'($urandom); E_bubble = 1'($urandom);
            M_icode = ($urandom_range(0, 1) == 0) ? 4'd7 : 4'($urandom); M_Cnd = 1'($urandom);
            rd_sel = 3'($urandom);
            step();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
